matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Sequences the i/j/k product loop for an NxN unsigned matrix multiply, N up to MAX_N.
- Generates read addresses for the A and B operand RAMs and owns the product accumulator.
- Writes each finished C element to the result RAM.
- Started by the top-level control FSM in its COMPUTE state; reports busy/done/err back to it.

Parameters:
- MAX_N, 8, largest supported matrix dimension.
- DATA_W, 8, operand element width (unsigned).
- ACC_W, 20, accumulator / C element width; must satisfy ACC_W >= 2*DATA_W + clog2(MAX_N).
- ADDR_W, 6, RAM address width; must satisfy 2^ADDR_W >= MAX_N*MAX_N.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a multiply
- size  in  4  matrix dimension N, sampled only in the start cycle
- rd_en  out  1  read strobe to A and B RAMs
- a_addr  out  ADDR_W  A read address, row-major i*N+k
- b_addr  out  ADDR_W  B read address, row-major k*N+j
- a_data  in  DATA_W  A read data, valid 1 cycle after rd_en
- b_data  in  DATA_W  B read data, valid 1 cycle after rd_en
- c_we  out  1  result RAM write strobe
- c_addr  out  ADDR_W  result address, i*N+j
- c_wdata  out  ACC_W  result element
- busy  out  1  multiply in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: illegal size on start

Behaviour:
- Reset: every output is 0; state IDLE; loop counters, latched N and accumulator cleared. rst has priority over all other inputs in every cycle.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - start=1 with 1 <= size <= MAX_N: latch N=size, clear i/j/k, go to RUN.
  - start=1 with size=0 or size>MAX_N: err=1 in the next cycle, stay IDLE, no RAM activity.
- RUN (one issue per cycle, no stalls):
  - Each cycle: rd_en=1, a_addr=i*N+k, b_addr=k*N+j.
  - k increments fastest, then j, then i; each index wraps N-1 -> 0.
  - After issuing (i,j,k)=(N-1,N-1,N-1), go to DRAIN.
  - Exactly N^3 consecutive rd_en cycles are issued.
- Pipeline stage 1 (cycle after each issue):
  - product = a_data*b_data, width 2*DATA_W, zero-extended to ACC_W.
  - If the delayed k is 0: acc = product. Otherwise acc = acc + product. No saturation; ACC_W is sized so overflow cannot occur.
- Pipeline stage 2 (cycle after the stage-1 accumulate with delayed k=N-1):
  - c_we=1, c_addr=delayed i*N+j, c_wdata=acc.
  - C elements are written in row-major order, exactly N^2 writes, one per address.
- DRAIN: rd_en=0; lasts 2 cycles so the final write completes, then go to FINISH.
- FINISH: done=1 for one cycle, then go to IDLE.
- Timing, start sampled in cycle 0:
  - rd_en in cycles 1..N^3.
  - Last c_we in cycle N^3+2.
  - done in cycle N^3+3.
  - busy=1 in cycles 1..N^3+3 inclusive.
- start asserted while busy is ignored; no err, no restart.
- The size input is ignored except in the accepted start cycle.
- rst mid-operation: outputs are 0 from the next cycle; no further c_we or done; a subsequent start behaves as from reset.
- a_addr, b_addr and c_addr hold their last values when their strobes are low; benches check them only when the strobe is high.

Test Plan:
- N=1, A[0]=3, B[0]=4, start at cycle 0 -> rd_en only in cycle 1 with a_addr=b_addr=0; c_we in cycle 3 with c_addr=0, c_wdata=12; done in cycle 4.
- N=2, A=[1,2,3,4], B=[5,6,7,8] -> c_we at addresses 0,1,2,3 with data 19,22,43,50, in that order; 8 rd_en cycles; done in cycle 11.
- N=3, A=[1..9], B=identity -> C=[1..9]; 27 rd_en cycles; exactly 9 c_we; done in cycle 30.
- size=0, then separately size=9 -> err=1 in cycle 1; rd_en, c_we and busy stay 0.
- N=2 run with start re-pulsed in cycle 4 -> the re-pulse is ignored and results match scenario 2. Separate run: rst in cycle 5 -> all outputs 0 from cycle 6 and no c_we afterwards; a new start with N=1 then completes correctly.
- N=8, all A and B elements 255 -> all 64 c_wdata = 520200 (no overflow); done in cycle 515.

Source files
------------

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Walks the i/j/k product loop of an NxN unsigned matrix multiply (N up to
// MAX_N). It issues one A/B operand read per cycle, accumulates the products
// of each dot product and writes every finished C element to the result RAM
// in row-major order.
//
// Pipeline (start sampled in cycle 0):
//   issue   : cycles 1..N^3, rd_en with a_addr=i*N+k, b_addr=k*N+j
//   stage 1 : one cycle later the RAM data is valid; acc restarts on k=0
//   stage 2 : the accumulate with k=N-1 is written out as c_we/c_addr/c_wdata
//   DRAIN   : two cycles so the final write leaves the pipe
//   FINISH  : one-cycle done pulse
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous, active-high reset (dominates every input)
//   start    in   single-cycle request to begin a multiply
//   size     in   matrix dimension N, sampled only in an accepted start cycle
//   rd_en    out  read strobe to A and B RAMs
//   a_addr   out  A read address, i*N+k
//   b_addr   out  B read address, k*N+j
//   a_data   in   A read data, valid one cycle after rd_en
//   b_data   in   B read data, valid one cycle after rd_en
//   c_we     out  result RAM write strobe
//   c_addr   out  result address, i*N+j
//   c_wdata  out  result element
//   busy     out  multiply in progress
//   done     out  one-cycle completion pulse
//   err      out  one-cycle pulse, illegal size seen on start
// -----------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int MAX_N  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [ACC_W-1:0]  c_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SIZE_W = 4;
    localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Control state
    state_t              state_q, state_d;
    logic [SIZE_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic                drain_cnt_q, drain_cnt_d;

    // Issue stage outputs
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
    logic [ADDR_W-1:0]   b_addr_q, b_addr_d;

    // Stage 1 tags travelling alongside the RAM read
    logic                v1_q, v1_d;
    logic                first_k1_q, first_k1_d;
    logic                last_k1_q, last_k1_d;
    logic [ADDR_W-1:0]   c1_q, c1_d;

    // Accumulator and stage 2 outputs
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                c_we_q, c_we_d;
    logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
    logic [ACC_W-1:0]    c_wdata_q, c_wdata_d;

    // Status outputs
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Helper combinational signals
    logic [IDX_W-1:0]    last_idx_s;
    logic                size_ok_s;
    logic [PROD_W-1:0]   product_s;
    logic [ACC_W-1:0]    product_ext_s;

    // Decode the last legal index value and whether the offered size is legal
    always_comb begin
        last_idx_s = IDX_W'(n_q - 4'd1);
        size_ok_s  = (size != 4'd0) && (32'(size) <= 32'(MAX_N));
    end

    // Loop FSM: next state, latched N, i/j/k counters and the err pulse
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_ok_s) begin
                        state_d = RUN;
                        n_d     = size;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // k runs fastest, then j, then i; the issue of (N-1,N-1,N-1) ends RUN
                if (k_q != last_idx_s) begin
                    k_d = k_q + IDX_W'(1);
                end else begin
                    k_d = '0;
                    if (j_q != last_idx_s) begin
                        j_d = j_q + IDX_W'(1);
                    end else begin
                        j_d = '0;
                        if (i_q != last_idx_s) begin
                            i_d = i_q + IDX_W'(1);
                        end else begin
                            i_d         = '0;
                            state_d     = DRAIN;
                            drain_cnt_d = 1'b0;
                        end
                    end
                end
            end
            DRAIN: begin
                // two cycles: lets the last product reach the write stage
                if (drain_cnt_q) begin
                    state_d = FINISH;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue stage: the read strobe and addresses for the index that will be live next cycle
    always_comb begin
        rd_en_d  = (state_d == RUN);
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        if (rd_en_d) begin
            a_addr_d = ADDR_W'(i_d) * ADDR_W'(n_d) + ADDR_W'(k_d);
            b_addr_d = ADDR_W'(k_d) * ADDR_W'(n_d) + ADDR_W'(j_d);
        end else begin
            a_addr_d = a_addr_q;
            b_addr_d = b_addr_q;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // Stage 1 tags: remember which k and which C element the outstanding read belongs to
    always_comb begin
        v1_d       = rd_en_q;
        first_k1_d = (k_q == '0);
        last_k1_d  = (k_q == last_idx_s);
        c1_d       = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
    end

    // Multiply-accumulate and result write; ACC_W is wide enough that no saturation is needed
    always_comb begin
        product_s     = {{DATA_W{1'b0}}, a_data} * {{DATA_W{1'b0}}, b_data};
        product_ext_s = {{(ACC_W - PROD_W){1'b0}}, product_s};
        acc_d         = acc_q;
        c_we_d        = 1'b0;
        c_addr_d      = c_addr_q;
        c_wdata_d     = c_wdata_q;
        if (v1_q) begin
            if (first_k1_q) begin
                acc_d = product_ext_s;
            end else begin
                acc_d = acc_q + product_ext_s;
            end
            if (last_k1_q) begin
                c_we_d    = 1'b1;
                c_addr_d  = c1_q;
                c_wdata_d = acc_d;
            end else begin
                c_we_d = 1'b0;
            end
        end else begin
            acc_d  = acc_q;
            c_we_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Issue and status output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q  <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_en_q  <= rd_en_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Datapath pipeline registers; clearing v1 on reset kills any write still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            first_k1_q <= 1'b0;
            last_k1_q  <= 1'b0;
            c1_q       <= '0;
            acc_q      <= '0;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            c_wdata_q  <= '0;
        end else begin
            v1_q       <= v1_d;
            first_k1_q <= first_k1_d;
            last_k1_q  <= last_k1_d;
            c1_q       <= c1_d;
            acc_q      <= acc_d;
            c_we_q     <= c_we_d;
            c_addr_q   <= c_addr_d;
            c_wdata_q  <= c_wdata_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign a_addr  = a_addr_q;
    assign b_addr  = b_addr_q;
    assign c_we    = c_we_q;
    assign c_addr  = c_addr_q;
    assign c_wdata = c_wdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for matmul_sequencer. A/B RAMs are modelled as one-cycle-latency
// arrays; expected read addresses, write timing and C values are derived from
// the cycle number and a plain triple-loop matrix product.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

    localparam int MAX_N  = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        size;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [ACC_W-1:0]  c_wdata;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] a_mem [0:63];
    logic [DATA_W-1:0] b_mem [0:63];
    longint            c_ref [0:63];
    logic [ACC_W-1:0]  c_got [0:63];
    int                wr_count;

    matmul_sequencer #(
        .MAX_N (MAX_N),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .size   (size),
        .rd_en  (rd_en),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_data (a_data),
        .b_data (b_data),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_wdata(c_wdata),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Operand RAMs: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end
    end

    task automatic compute_ref(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                longint s = 0;
                for (int k = 0; k < n; k++) begin
                    s += longint'(a_mem[i*n+k]) * longint'(b_mem[k*n+j]);
                end
                c_ref[i*n+j] = s;
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int e = 0; e < 64; e++) begin
            a_mem[e] = 8'($urandom_range(0, 255));
            b_mem[e] = 8'($urandom_range(0, 255));
        end
        compute_ref(n);
    endtask

    // Starts an N x N multiply at a negedge (cycle 0) and checks every cycle.
    // repulse_t > 1 re-asserts start with a random size in that cycle.
    task automatic run_matmul(input string name, input int n, input int repulse_t);
        int n3;
        n3 = n * n * n;
        compute_ref(n);
        wr_count = 0;
        @(negedge clk);
        start = 1'b1;
        size  = 4'(n);
        for (int t = 1; t <= n3 + 6; t++) begin
            bit exp_rd, exp_we;
            int s, ei, ej, ek, e;
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (t == repulse_t) begin
                start = 1'b1;
                size  = 4'($urandom_range(0, 15));
            end
            if (t == repulse_t + 1) start = 1'b0;

            exp_rd = (t >= 1) && (t <= n3);
            checks++;
            if (rd_en !== exp_rd) begin
                errors++;
                $display("FAIL %s rd_en t=%0d got %b exp %b", name, t, rd_en, exp_rd);
            end
            if (exp_rd) begin
                s  = t - 1;
                ei = s / (n * n);
                ej = (s / n) % n;
                ek = s % n;
                checks++;
                if (a_addr !== ADDR_W'(ei*n+ek) || b_addr !== ADDR_W'(ek*n+ej)) begin
                    errors++;
                    $display("FAIL %s addr t=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                             name, t, a_addr, b_addr, ei*n+ek, ek*n+ej);
                end
            end

            // element e is written two cycles after its k=N-1 issue, i.e. cycle (e+1)*N+2
            exp_we = (t >= n + 2) && ((t - 2) % n == 0) && ((t - 2) / n <= n * n);
            checks++;
            if (c_we !== exp_we) begin
                errors++;
                $display("FAIL %s c_we t=%0d got %b exp %b", name, t, c_we, exp_we);
            end
            if (c_we === 1'b1) wr_count++;
            if (exp_we) begin
                e = (t - 2) / n - 1;
                c_got[e] = c_wdata;
                checks++;
                if (c_addr !== ADDR_W'(e) || c_wdata !== ACC_W'(c_ref[e])) begin
                    errors++;
                    $display("FAIL %s c_write t=%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                             name, t, c_addr, c_wdata, e, c_ref[e]);
                end
            end

            checks++;
            if (busy !== ((t >= 1) && (t <= n3 + 3)) || done !== (t == n3 + 3) || err !== 1'b0) begin
                errors++;
                $display("FAIL %s status t=%0d got busy=%b done=%b err=%b", name, t, busy, done, err);
            end
        end
        checks++;
        if (wr_count !== n * n) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, wr_count, n * n);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        size  = 4'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({rd_en, c_we, busy, done, err, a_addr, b_addr, c_addr, c_wdata} !== '0) begin
                errors++;
                $display("FAIL reset outputs cycle=%0d got rd_en=%b c_we=%b busy=%b done=%b err=%b",
                         c, rd_en, c_we, busy, done, err);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        size  = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_n1();
        a_mem[0] = 8'd3;
        b_mem[0] = 8'd4;
        run_matmul("n1", 1, 0);
        checks++;
        if (c_got[0] !== 20'd12) begin
            errors++;
            $display("FAIL n1_value got %0d exp 12", c_got[0]);
        end
    endtask

    task automatic load_n2();
        for (int e = 0; e < 4; e++) begin
            a_mem[e] = 8'(e + 1);
            b_mem[e] = 8'(e + 5);
        end
    endtask

    task automatic test_n2(input string name, input int repulse_t);
        int exp_c [4] = '{19, 22, 43, 50};
        load_n2();
        run_matmul(name, 2, repulse_t);
        for (int e = 0; e < 4; e++) begin
            checks++;
            if (c_got[e] !== ACC_W'(exp_c[e])) begin
                errors++;
                $display("FAIL %s value[%0d] got %0d exp %0d", name, e, c_got[e], exp_c[e]);
            end
        end
    endtask

    task automatic test_n3_identity();
        for (int e = 0; e < 9; e++) begin
            a_mem[e] = 8'(e + 1);
            b_mem[e] = ((e % 4) == 0) ? 8'd1 : 8'd0;
        end
        run_matmul("n3_identity", 3, 0);
        for (int e = 0; e < 9; e++) begin
            checks++;
            if (c_got[e] !== ACC_W'(e + 1)) begin
                errors++;
                $display("FAIL n3_identity value[%0d] got %0d exp %0d", e, c_got[e], e + 1);
            end
        end
    endtask

    task automatic test_err();
        int bad [3] = '{0, 9, 15};
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            start = 1'b1;
            size  = 4'(bad[b]);
            for (int t = 1; t <= 4; t++) begin
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (err !== (t == 1) || rd_en !== 1'b0 || c_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL err_size%0d t=%0d got err=%b rd_en=%b c_we=%b busy=%b done=%b",
                             bad[b], t, err, rd_en, c_we, busy, done);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        load_n2();
        @(negedge clk);
        start = 1'b1;
        size  = 4'd2;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (rd_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid pre t=%0d got rd_en=%b busy=%b exp 1 1", t, rd_en, busy);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 6; t <= 25; t++) begin
            checks++;
            if ({rd_en, c_we, busy, done, err, a_addr, b_addr, c_addr, c_wdata} !== '0) begin
                errors++;
                $display("FAIL rst_mid post t=%0d got rd_en=%b c_we=%b busy=%b done=%b c_wdata=%0d",
                         t, rd_en, c_we, busy, done, c_wdata);
            end
            @(negedge clk);
        end
        test_n1();
    endtask

    task automatic test_n8_max();
        for (int e = 0; e < 64; e++) begin
            a_mem[e] = 8'd255;
            b_mem[e] = 8'd255;
        end
        run_matmul("n8_max", 8, 0);
        for (int e = 0; e < 64; e++) begin
            checks++;
            if (c_got[e] !== 20'd520200) begin
                errors++;
                $display("FAIL n8_max value[%0d] got %0d exp 520200", e, c_got[e]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, MAX_N);
            fill_random(n);
            run_matmul("random", n, (r % 2 == 1) ? $urandom_range(2, n * n * n + 2) : 0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        size   = 4'd0;
        a_data = '0;
        b_data = '0;
        test_reset();
        test_n1();
        test_n2("n2", 0);
        test_n3_identity();
        test_err();
        test_n2("n2_repulse", 4);
        test_rst_mid();
        test_n8_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
